vram_ctrl: RTL and testbench

Single-port VRAM controller. It is the responder for the core's `vram_active`/`vram_w`/`vram_ready` load/store handshake, and also serves pixel reads from the video scan-out engine over an identical handshake. It arbitrates the two requesters round-robin onto one synchronous SRAM with 1-cycle read latency, and returns a one-cycle ready/ack pulse per transaction.

---
 rtl/vram_ctrl.sv | 169 ++++++++++++++++
 tb/tb_vram_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_ctrl.sv
// Single-port VRAM controller: round-robin arbitration between the CPU load/store
// port and the video scan-out read port onto one synchronous SRAM (1-cycle read latency).
module vram_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 19200
) (
  input  logic              clk,
  input  logic              rst,
  // CPU load/store port
  input  logic              vram_active,
  input  logic              vram_w,
  input  logic [ADDR_W-1:0] vram_addr,
  input  logic [DATA_W-1:0] vram_in,
  output logic [DATA_W-1:0] vram_out,
  output logic              vram_ready,
  // video scan-out read port
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_ack,
  // synchronous SRAM
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_RESP
  } state_t;

  typedef enum logic {
    PORT_CPU,
    PORT_VID
  } port_t;

  state_t            state_q, state_d;
  port_t             owner_q, owner_d;
  port_t             last_q,  last_d;
  logic              op_w_q,  op_w_d;
  logic              oor_q,   oor_d;
  logic [ADDR_W-1:0] op_addr_q, op_addr_d;
  logic [DATA_W-1:0] op_data_q, op_data_d;

  logic  grant_en;
  port_t grant_port;

  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return 64'(a) >= 64'(DEPTH);
  endfunction

  // Next-state, arbitration and operand capture.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    op_w_d     = op_w_q;
    oor_d      = oor_q;
    op_addr_d  = op_addr_q;
    op_data_d  = op_data_q;
    grant_en   = 1'b0;
    grant_port = PORT_CPU;

    unique case (state_q)
      S_IDLE: begin
        if (vram_active && vid_req) begin
          grant_en   = 1'b1;
          grant_port = (last_q == PORT_CPU) ? PORT_VID : PORT_CPU;
        end else if (vram_active) begin
          grant_en   = 1'b1;
          grant_port = PORT_CPU;
        end else if (vid_req) begin
          grant_en   = 1'b1;
          grant_port = PORT_VID;
        end
      end
      S_ACC: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        // The owner's own request is ignored here: the CPU only drops it off vram_ready.
        last_d  = owner_q;
        state_d = S_IDLE;
        if (owner_q == PORT_CPU && vid_req) begin
          grant_en   = 1'b1;
          grant_port = PORT_VID;
        end else if (owner_q == PORT_VID && vram_active) begin
          grant_en   = 1'b1;
          grant_port = PORT_CPU;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (grant_en) begin
      state_d = S_ACC;
      owner_d = grant_port;
      if (grant_port == PORT_CPU) begin
        op_w_d    = vram_w;
        op_addr_d = vram_addr;
        op_data_d = vram_in;
        oor_d     = out_of_range(vram_addr);
      end else begin
        op_w_d    = 1'b0;
        op_addr_d = vid_addr;
        op_data_d = '0;
        oor_d     = out_of_range(vid_addr);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      owner_q   <= PORT_CPU;
      last_q    <= PORT_VID;
      op_w_q    <= 1'b0;
      oor_q     <= 1'b0;
      op_addr_q <= '0;
      op_data_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      op_w_q    <= op_w_d;
      oor_q     <= oor_d;
      op_addr_q <= op_addr_d;
      op_data_q <= op_data_d;
    end
  end

  // Outputs decode from registered state only, so reset forces them all to 0 at once.
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;
    vram_ready = 1'b0;
    vram_out   = '0;
    vid_ack    = 1'b0;
    vid_data   = '0;

    unique case (state_q)
      S_ACC: begin
        mem_en   = !oor_q;
        mem_we   = op_w_q && !oor_q;
        mem_addr = op_addr_q;
        mem_din  = op_data_q;
      end
      S_RESP: begin
        if (owner_q == PORT_CPU) begin
          vram_ready = 1'b1;
          if (!op_w_q && !oor_q) vram_out = mem_dout;
        end else begin
          vid_ack = 1'b1;
          if (!oor_q) vid_data = mem_dout;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vram_ctrl.sv
// Self-checking bench for vram_ctrl: directed handshake/latency steps plus randomized
// contention traffic scored against a flat memory-array reference model.
module tb_vram_ctrl;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 19200;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              vram_active = 1'b0;
  logic              vram_w = 1'b0;
  logic [ADDR_W-1:0] vram_addr = '0;
  logic [DATA_W-1:0] vram_in = '0;
  logic [DATA_W-1:0] vram_out;
  logic              vram_ready;
  logic              vid_req = 1'b0;
  logic [ADDR_W-1:0] vid_addr = '0;
  logic [DATA_W-1:0] vid_data;
  logic              vid_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  vram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .vram_active(vram_active), .vram_w(vram_w), .vram_addr(vram_addr),
    .vram_in(vram_in), .vram_out(vram_out), .vram_ready(vram_ready),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_ack(vid_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM with 1-cycle read latency; cleared once at start of run.
  logic [DATA_W-1:0] sram [DEPTH];
  logic              sram_clr = 1'b1;
  always @(posedge clk) begin
    if (sram_clr) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= '0;
      mem_dout <= '0;
    end else if (mem_en && int'(mem_addr) < DEPTH) begin
      if (mem_we) sram[int'(mem_addr)] <= mem_din;
      else        mem_dout <= sram[int'(mem_addr)];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model: what memory should hold after each completed transaction.
  logic [DATA_W-1:0] ref_mem [DEPTH];

  function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    return (int'(a) < DEPTH) ? ref_mem[int'(a)] : '0;
  endfunction

  task automatic ref_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (int'(a) < DEPTH) ref_mem[int'(a)] = d;
  endtask

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    check({tag, "_ready"}, vram_ready, 0);
    check({tag, "_ack"},   vid_ack,    0);
    check({tag, "_en"},    mem_en,     0);
    check({tag, "_we"},    mem_we,     0);
    check({tag, "_addr"},  mem_addr,   0);
    check({tag, "_din"},   mem_din,    0);
    check({tag, "_out"},   vram_out,   0);
    check({tag, "_vdata"}, vid_data,   0);
  endtask

  // One isolated CPU transaction with the latency-2 timing checked cycle by cycle.
  task automatic cpu_txn(input string tag, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    logic in_range;
    in_range    = int'(a) < DEPTH;
    vram_active = 1'b1;
    vram_w      = w;
    vram_addr   = a;
    vram_in     = d;
    tick();
    check({tag, "_acc_en"},    mem_en, 32'(in_range));
    check({tag, "_acc_we"},    mem_we, 32'(in_range && w));
    check({tag, "_acc_ready"}, vram_ready, 0);
    if (in_range) check({tag, "_acc_addr"}, mem_addr, 32'(a));
    if (in_range && w) check({tag, "_acc_din"}, mem_din, 32'(d));
    tick();
    check({tag, "_ready"}, vram_ready, 1);
    check({tag, "_resp_we"}, mem_we, 0);
    if (!w) check({tag, "_rdata"}, vram_out, 32'(ref_rd(a)));
    else    ref_wr(a, d);
    vram_active = 1'b0;
    tick();
    check({tag, "_ready_off"}, vram_ready, 0);
    check({tag, "_out_off"},   vram_out, 0);
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(0, 15) == 0) return ADDR_W'(DEPTH + int'($urandom_range(0, 100)));
    return ADDR_W'($urandom_range(0, 63));
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic              cw;
    logic [ADDR_W-1:0] ca;
    logic [DATA_W-1:0] cd;
    logic [ADDR_W-1:0] va;
    int                done;
    int                last_cyc;
    int                last_port;
    logic              saw_ready;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset state.
    tick();
    sram_clr = 1'b0;
    chk_all_zero("reset");
    tick();
    rst = 1'b1;
    tick();
    chk_all_zero("idle");

    // CPU write then read.
    cpu_txn("wr_beef", 1'b1, 16'h0010, 16'hBEEF);
    cpu_txn("rd_beef", 1'b0, 16'h0010, 16'h0000);

    // Out-of-range accesses.
    cpu_txn("oor_wr", 1'b1, ADDR_W'(DEPTH), 16'h1234);
    cpu_txn("oor_rd", 1'b0, ADDR_W'(DEPTH + 5), 16'h0000);
    cpu_txn("oor_wrap_rd", 1'b0, 16'h0000, 16'h0000);

    // Request dropped right after grant: write still lands.
    vram_active = 1'b1; vram_w = 1'b1; vram_addr = 16'd3; vram_in = 16'h00AA;
    tick();
    vram_active = 1'b0;
    vram_in     = 16'hFFFF;
    check("drop_we",  mem_we,  1);
    check("drop_din", mem_din, 32'h00AA);
    tick();
    check("drop_ready", vram_ready, 1);
    ref_wr(16'd3, 16'h00AA);
    tick();
    cpu_txn("drop_rd", 1'b0, 16'd3, 16'h0000);

    // Reset asserted during S_ACC of a write: outputs clear, write discarded.
    vram_active = 1'b1; vram_w = 1'b1; vram_addr = 16'h0020; vram_in = 16'h5555;
    tick();
    check("midrst_acc_we", mem_we, 1);
    rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    vram_active = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    saw_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      saw_ready = saw_ready | vram_ready | vid_ack | mem_en;
    end
    check("midrst_quiet", saw_ready, 0);
    cpu_txn("midrst_rd", 1'b0, 16'h0020, 16'h0000);

    // Simultaneous requests right after reset: CPU wins the first tie.
    cpu_txn("pre1", 1'b1, 16'd1, 16'h1111);
    cpu_txn("pre2", 1'b1, 16'd2, 16'h2222);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    vram_active = 1'b1; vram_w = 1'b0; vram_addr = 16'd1;
    vid_req     = 1'b1; vid_addr = 16'd2;
    tick();
    check("tie_acc_addr", mem_addr, 1);
    check("tie_acc_pulses", {vram_ready, vid_ack}, 0);
    tick();
    check("tie_cpu_ready", vram_ready, 1);
    check("tie_cpu_noack", vid_ack, 0);
    check("tie_cpu_data", vram_out, 32'h1111);
    vram_active = 1'b0;
    tick();
    check("tie_gap_pulses", {vram_ready, vid_ack}, 0);
    check("tie_vid_acc_addr", mem_addr, 2);
    check("tie_vid_acc_we", mem_we, 0);
    tick();
    check("tie_vid_ack", vid_ack, 1);
    check("tie_vid_noready", vram_ready, 0);
    check("tie_vid_data", vid_data, 32'h2222);
    vid_req = 1'b0;
    tick();
    check("tie_vid_ack_off", vid_ack, 0);
    check("tie_vid_data_off", vid_data, 0);

    // Video alone: one completion every 3 cycles.
    va = ADDR_W'($urandom_range(0, 63));
    vid_addr = va;
    vid_req  = 1'b1;
    done = 0;
    last_cyc = 0;
    for (int k = 0; k < 40 && done < 4; k++) begin
      tick();
      check("solo_no_cpu", vram_ready, 0);
      if (vid_ack) begin
        check("solo_data", vid_data, 32'(ref_rd(va)));
        if (done > 0) check("solo_gap", cyc - last_cyc, 3);
        last_cyc = cyc;
        done++;
        va = ADDR_W'($urandom_range(0, 63));
        vid_addr = va;
      end
    end
    check("solo_count", done, 4);
    vid_req = 1'b0;
    tick();
    tick();

    // Sustained contention with random CPU reads/writes and video reads.
    cw = 1'($urandom_range(0, 1)); ca = rand_addr(); cd = DATA_W'($urandom);
    va = rand_addr();
    vram_active = 1'b1; vram_w = cw; vram_addr = ca; vram_in = cd;
    vid_req = 1'b1; vid_addr = va;
    done = 0;
    last_cyc = 0;
    last_port = -1;
    for (int k = 0; k < 200 && done < 20; k++) begin
      tick();
      check("cont_overlap", vram_ready & vid_ack, 0);
      if (vram_ready) begin
        if (!cw) check("cont_cpu_rdata", vram_out, 32'(ref_rd(ca)));
        else     ref_wr(ca, cd);
        if (done > 0) begin
          check("cont_gap", cyc - last_cyc, 2);
          check("cont_alt", last_port, 1);
        end
        last_port = 0;
        last_cyc  = cyc;
        done++;
        cw = 1'($urandom_range(0, 1)); ca = rand_addr(); cd = DATA_W'($urandom);
        vram_w = cw; vram_addr = ca; vram_in = cd;
      end else if (vid_ack) begin
        check("cont_vid_rdata", vid_data, 32'(ref_rd(va)));
        if (done > 0) begin
          check("cont_gap", cyc - last_cyc, 2);
          check("cont_alt", last_port, 0);
        end
        last_port = 1;
        last_cyc  = cyc;
        done++;
        va = rand_addr();
        vid_addr = va;
      end
      if (done == 20) begin
        vram_active = 1'b0;
        vid_req     = 1'b0;
      end
    end
    check("cont_count", done, 20);
    vram_active = 1'b0;
    vid_req     = 1'b0;
    tick();
    tick();
    check("final_idle", {vram_ready, vid_ack, mem_en}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
